// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks a register-file address range and streams (addr, data) pairs over valid/ready
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_first_addr,
    input  logic [ADDR_W-1:0] i_last_addr,
    output logic [ADDR_W-1:0] o_rf_rd_addr,
    input  logic [DATA_W-1:0] i_rf_rd_dat,
    output logic              o_busy,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_done
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rd_addr_d = rd_addr_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        done_d    = done_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    last_d    = i_last_addr;
                    rd_addr_d = i_first_addr;
                    cnt_d     = CNT_W'(RD_LAT);
                    busy_d    = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Read data is valid once the address has been stable for RD_LAT cycles.
                if (cnt_q == CNT_W'(1)) begin
                    dat_d   = i_rf_rd_dat;
                    addr_d  = rd_addr_q;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        cnt_d     = CNT_W'(RD_LAT);
                        state_d   = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the handshake outputs but leaves the address/data registers as they were.
        if (i_abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            valid_d   = 1'b0;
            done_d    = 1'b0;
            cnt_d     = cnt_q;
            rd_addr_d = rd_addr_q;
            addr_d    = addr_q;
            dat_d     = dat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            rd_addr_q <= '0;
            addr_q    <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign o_rf_rd_addr = rd_addr_q;
    assign o_busy       = busy_q;
    assign o_valid      = valid_q;
    assign o_addr       = addr_q;
    assign o_dat        = dat_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed self-checking bench for regfile_dump
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3, abort, ready;
    logic [4:0]  f_addr, l_addr;
    logic [4:0]  rd_addr, addr, rd_addr3, addr3;
    logic [31:0] rd_dat, dat, rd_dat3, dat3;
    logic        busy, valid, done, busy3, valid3, done3;
    logic [31:0] rf [32];
    logic [31:0] d1, d2;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    always #5 clk = ~clk;

    assign rd_dat = rf[rd_addr];

    always @(posedge clk) begin
        d1 <= rf[rd_addr3];
        d2 <= d1;
    end
    assign rd_dat3 = d2;

    regfile_dump #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_first_addr(f_addr), .i_last_addr(l_addr),
        .o_rf_rd_addr(rd_addr), .i_rf_rd_dat(rd_dat),
        .o_busy(busy), .o_valid(valid), .i_ready(ready),
        .o_addr(addr), .o_dat(dat), .o_done(done)
    );

    regfile_dump #(.DATA_W(32), .ADDR_W(5), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .i_start(start3), .i_abort(abort),
        .i_first_addr(f_addr), .i_last_addr(l_addr),
        .o_rf_rd_addr(rd_addr3), .i_rf_rd_dat(rd_dat3),
        .o_busy(busy3), .o_valid(valid3), .i_ready(ready),
        .o_addr(addr3), .o_dat(dat3), .o_done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_dat(input logic [4:0] a);
        return 32'({27'd0, a}) * 32'h0101_0101;
    endfunction

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int exp_n,
                            input bit toggle, output int cycles);
        int n;
        logic [4:0] ea;
        n = 0;
        cycles = 0;
        f_addr = f;
        l_addr = l;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        f_addr = 5'd17;
        l_addr = 5'd18;
        check("busy_on", busy, 1);
        check("rdaddr_first", rd_addr, f);
        while (!done && cycles < 400) begin
            if (toggle) ready = (cycles % 2 == 0);
            if (valid) begin
                ea = f + n[4:0];
                check("entry_addr", addr, ea);
                check("entry_dat", dat, exp_dat(ea));
                if (ready) n++;
            end
            tick();
            cycles++;
        end
        check("done_seen", done, 1);
        check("entry_count", n, exp_n);
        tick();
        check("done_pulse_end", done, 0);
        check("busy_off", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = exp_dat(i[4:0]);
        rst = 1'b1; start = 1'b1; start3 = 1'b0; abort = 1'b0; ready = 1'b0;
        f_addr = 5'd3; l_addr = 5'd9;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_rdaddr", rd_addr, 0);
        check("rst_addr", addr, 0);
        check("rst_dat", dat, 0);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", busy, 0);
        end

        // single entry at x5
        rf[5] = 32'hDEAD_BEEF;
        f_addr = 5'd5; l_addr = 5'd5; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("single_rdaddr", rd_addr, 5);
        check("single_busy", busy, 1);
        check("single_valid_early", valid, 0);
        tick();
        check("single_valid", valid, 1);
        check("single_addr", addr, 5);
        check("single_dat", dat, 32'hDEAD_BEEF);
        tick();
        check("single_done", done, 1);
        check("single_valid_drop", valid, 0);
        tick();
        check("single_done_end", done, 0);
        check("single_busy_end", busy, 0);
        rf[5] = exp_dat(5'd5);

        run_dump(5'd0, 5'd31, 32, 1'b1, cyc);
        run_dump(5'd30, 5'd1, 4, 1'b0, cyc);
        check("wrap_cycles", cyc, 8);
        run_dump(5'd4, 5'd3, 32, 1'b0, cyc);
        check("full_cycles", cyc, 64);

        // abort while the third entry is presented
        f_addr = 5'd0; l_addr = 5'd31; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(valid && addr == 5'd2) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("abort_reach_third", valid && addr == 5'd2, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rdaddr_held", rd_addr, 2);
        check("abort_addr_held", addr, 2);
        check("abort_dat_held", dat, exp_dat(5'd2));
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        run_dump(5'd3, 5'd4, 2, 1'b0, cyc);

        // start and abort together in idle
        f_addr = 5'd20; l_addr = 5'd21; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_rdaddr", rd_addr, 4);
        tick();
        check("sa_valid", valid, 0);

        // RD_LAT=3 instance
        f_addr = 5'd7; l_addr = 5'd7; ready = 1'b1; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("lat3_rdaddr", rd_addr3, 7);
        check("lat3_valid0", valid3, 0);
        tick();
        check("lat3_valid1", valid3, 0);
        tick();
        check("lat3_valid2", valid3, 0);
        tick();
        check("lat3_valid3", valid3, 1);
        check("lat3_addr", addr3, 7);
        check("lat3_dat", dat3, 32'h0707_0707);
        tick();
        check("lat3_done", done3, 1);
        tick();
        check("lat3_busy_end", busy3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
